// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared types for the sram_port front end.
package sram_port_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/sram_port_if.sv
// sram_port_if: request/response bus between a pipeline stage and sram_port.
interface sram_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  init_done;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/sram_port_array.sv
// sram_array: raw single-port array with bit write mask and registered read; no reset so a foundry macro can drop in.
module sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] bwen,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (ce && we) mem[a] <= (mem[a] & ~bwen) | (d & bwen);
    if (ce && !we) q <= mem[a];
  end
endmodule

// File: rtl/sram_port.sv
// sram_port: valid/ready SRAM front end with masked writes, range check and power-on zero fill.
module sram_port
  import sram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int INIT_ZERO  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  sram_port_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);
  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   fill_addr;
  logic                  rsp_valid, rsp_err, in_range, accept, init;
  logic                  ce, we;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d, bwen, q;
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_chk
    assign in_range = {1'b0, bus.req_addr} < LIMIT;
  end
  assign init          = state == ST_INIT;
  assign bus.req_ready = rst_n && !init && (!rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = (init && fill_addr == LAST) ? ST_RUN : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) fill_addr <= '0;
    else if (init) fill_addr <= fill_addr + 1'b1;
  end
  // one-deep response slot; a new read refills it in the same edge it is popped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept && !bus.req_write) begin
      rsp_valid <= 1'b1;
      rsp_err   <= !in_range;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end
  end
  always_comb begin
    ce   = init || (accept && in_range);
    we   = init || bus.req_write;
    a    = init ? fill_addr[ADDR_WIDTH-1:0] : bus.req_addr;
    d    = init ? '0 : bus.req_wdata;
    bwen = init ? '1 : bus.req_wmask;
  end
  sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk (clk),
    .ce  (ce),
    .we  (we),
    .a   (a),
    .d   (d),
    .bwen(bwen),
    .q   (q)
  );
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = (rsp_valid && !rsp_err) ? q : '0;
  assign bus.init_done = !init;
endmodule
